// File: rtl/chacha_qr_pkg.sv
// ----------------------------------------------------------------------------
// chacha_qr_pkg
//   Shared types and constants for the ChaCha quarter-round host initiator:
//   FSM state encoding, bus field widths, address field positions and the
//   bit positions of the wr/qr strobes on the core's uio_in pins.
//   Also provides a byte-select helper over the packed 128-bit {d,c,b,a} state.
// ----------------------------------------------------------------------------
package chacha_qr_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned STATE_W   = NUM_BYTES * DATA_W;

  // Bus address = {reg[1:0], byte[1:0]}; reg 0=a..3=d, byte 0 = bits [7:0].
  localparam int unsigned REG_MSB  = 3;
  localparam int unsigned REG_LSB  = 2;
  localparam int unsigned BYTE_MSB = 1;
  localparam int unsigned BYTE_LSB = 0;

  // Strobe positions on the core's uio_in bus.
  localparam int unsigned UIO_WR_BIT = 7;
  localparam int unsigned UIO_QR_BIT = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_QR    = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Byte k of the packed state; since reg-major addressing matches the
  // {d,c,b,a} packing, bus address k is simply bits [8k+7:8k].
  function automatic logic [DATA_W-1:0] byte_of(input logic [STATE_W-1:0] s,
                                                input logic [ADDR_W-1:0]  idx);
    byte_of = s[{idx, 3'b000} +: DATA_W];
  endfunction

endpackage

// File: rtl/chacha_qr_rd_pipe.sv
// ----------------------------------------------------------------------------
// chacha_qr_rd_pipe
//   DEPTH-deep shift register of {valid, byte index} that tracks each READ
//   address issue until its data is present on bus_data_i, so the top can
//   capture exactly the byte that belongs to that address.
// Ports
//   clk, rst   clock, synchronous active-high reset (clears all stages)
//   i_valid    an address is being issued this cycle
//   i_idx      the issued byte address
//   o_valid    capture enable: bus_data_i holds the byte for o_idx
//   o_idx      byte index to capture into
// ----------------------------------------------------------------------------
import chacha_qr_pkg::*;

module chacha_qr_rd_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_idx,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_idx
);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_idx [DEPTH];

  // Shift issue tags one stage per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_idx[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_idx[0]   <= i_idx;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/chacha_qr_host.sv
// ----------------------------------------------------------------------------
// chacha_qr_host
//   Host-side initiator for the ChaCha quarter-round byte bus. Accepts a
//   128-bit {d,c,b,a} state, writes it byte by byte into the QR core,
//   optionally pulses qr for QR_CYCLES cycles, reads all 16 bytes back and
//   presents the result on a valid/ready output port.
// Parameters
//   QR_CYCLES     cycles bus_qr_o is held high per operation (1..15)
//   READ_LATENCY  edges from address presented to bus_data_i valid (1..4)
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_state/in_qr           request payload ([31:0]=a .. [127:96]=d)
//   in_valid/in_ready        request handshake (ready only in IDLE)
//   out_state/out_valid      result, held until out_ready
//   out_ready                result consumer ready
//   busy                     any state other than IDLE
//   bus_data_o/bus_addr_o    write byte / {reg,byte} address to the core
//   bus_wr_o/bus_qr_o        write and quarter-round strobes
//   bus_data_i               read-back byte from the core
// ----------------------------------------------------------------------------
import chacha_qr_pkg::*;

module chacha_qr_host #(
  parameter int unsigned QR_CYCLES    = 1,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_qr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [DATA_W-1:0]  bus_data_o,
  output logic [ADDR_W-1:0]  bus_addr_o,
  output logic               bus_wr_o,
  output logic               bus_qr_o,
  input  logic [DATA_W-1:0]  bus_data_i
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] QR_LAST   = ADDR_W'(QR_CYCLES - 1);

  state_e             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [DATA_W-1:0]  r_data, w_data_nxt;
  logic               r_wr, w_wr_nxt;
  logic               r_qr, w_qr_nxt;
  logic [ADDR_W-1:0]  r_qcnt, w_qcnt_nxt;
  logic               r_issue_done, w_issue_done_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               w_accept;
  logic [STATE_W-1:0] r_lat_state;
  logic               r_lat_qr;
  logic [STATE_W-1:0] r_out_state;
  logic               w_issue_v;
  logic               w_cap_v;
  logic [ADDR_W-1:0]  w_cap_idx;

  // An address is issued on every READ cycle until byte 15 has gone out;
  // the remaining READ cycles only drain the capture pipe.
  assign w_issue_v = (r_state == ST_READ) && !r_issue_done;

  chacha_qr_rd_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_issue_v),
    .i_idx   (r_addr),
    .o_valid (w_cap_v),
    .o_idx   (w_cap_idx)
  );

  // Next-state and next bus values; all bus outputs are registered.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = 4'd0;
    w_data_nxt       = 8'd0;
    w_wr_nxt         = 1'b0;
    w_qr_nxt         = 1'b0;
    w_qcnt_nxt       = r_qcnt;
    w_issue_done_nxt = r_issue_done;
    w_out_valid_nxt  = 1'b0;
    w_accept         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WRITE;
          w_wr_nxt    = 1'b1;
          w_data_nxt  = byte_of(in_state, 4'd0);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (r_addr == ADDR_LAST) begin
          w_issue_done_nxt = 1'b0;
          w_qcnt_nxt       = 4'd0;
          if (r_lat_qr) begin
            w_state_nxt = ST_QR;
            w_qr_nxt    = 1'b1;
          end else begin
            w_state_nxt = ST_READ;
          end
        end else begin
          w_wr_nxt   = 1'b1;
          w_addr_nxt = r_addr + 4'd1;
          w_data_nxt = byte_of(r_lat_state, r_addr + 4'd1);
        end
      end
      ST_QR: begin
        if (r_qcnt == QR_LAST) begin
          w_state_nxt = ST_READ;
        end else begin
          w_qr_nxt   = 1'b1;
          w_qcnt_nxt = r_qcnt + 4'd1;
        end
      end
      ST_READ: begin
        // Address holds at 15 once issuing is finished (drain cycles).
        if (r_issue_done) begin
          w_addr_nxt = ADDR_LAST;
        end else if (r_addr == ADDR_LAST) begin
          w_issue_done_nxt = 1'b1;
          w_addr_nxt       = ADDR_LAST;
        end else begin
          w_addr_nxt = r_addr + 4'd1;
        end
        // Final byte lands on the same edge that enters DONE.
        if (w_cap_v && (w_cap_idx == ADDR_LAST)) begin
          w_state_nxt     = ST_DONE;
          w_addr_nxt      = 4'd0;
          w_out_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_out_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, bus output and request latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= 4'd0;
      r_data       <= 8'd0;
      r_wr         <= 1'b0;
      r_qr         <= 1'b0;
      r_qcnt       <= 4'd0;
      r_issue_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_lat_state  <= '0;
      r_lat_qr     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_wr         <= w_wr_nxt;
      r_qr         <= w_qr_nxt;
      r_qcnt       <= w_qcnt_nxt;
      r_issue_done <= w_issue_done_nxt;
      r_out_valid  <= w_out_valid_nxt;
      if (w_accept) begin
        r_lat_state <= in_state;
        r_lat_qr    <= in_qr;
      end else begin
        r_lat_state <= r_lat_state;
        r_lat_qr    <= r_lat_qr;
      end
    end
  end

  // Read-back capture; a reset discards any partially read result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_state <= '0;
    end else if (w_cap_v) begin
      r_out_state[{w_cap_idx, 3'b000} +: DATA_W] <= bus_data_i;
    end else begin
      r_out_state <= r_out_state;
    end
  end

  // in_ready is masked by rst so it reads 0 for the whole reset window.
  assign in_ready   = (r_state == ST_IDLE) && !rst;
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = r_out_valid;
  assign out_state  = r_out_state;
  assign bus_data_o = r_data;
  assign bus_addr_o = r_addr;
  assign bus_wr_o   = r_wr;
  assign bus_qr_o   = r_qr;

endmodule

// File: tb/tb_chacha_qr_host.sv
// ----------------------------------------------------------------------------
// tb_chacha_qr_host
//   Drives chacha_qr_host against a behavioural QR core responder. dut0 uses
//   registered readback (READ_LATENCY=1); dut1 adds one extra register on the
//   read path (READ_LATENCY=2). A transaction-level model predicts dut0's
//   outputs on every cycle from the cycle offset since acceptance.
// ----------------------------------------------------------------------------
module tb_chacha_qr_host;

  localparam int QR_CYC = 1;
  localparam int RL0    = 1;
  localparam logic [127:0] LB    = 128'h01234567_9b8d6f43_01020304_11111111;
  localparam logic [127:0] QRES  = 128'h5881c4bb_4581472e_cb1cf8ce_ea2a92f4;
  localparam logic [127:0] TRACE = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] in_state0 = '0, out_state0;
  logic in_qr0 = 1'b0, in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0, busy0;
  logic [7:0] bus_data_o0, bus_data_i0;
  logic [3:0] bus_addr_o0;
  logic bus_wr_o0, bus_qr_o0;

  logic [127:0] in_state1 = '0, out_state1;
  logic in_qr1 = 1'b0, in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, busy1;
  logic [7:0] bus_data_o1, bus_data_i1;
  logic [3:0] bus_addr_o1;
  logic bus_wr_o1, bus_qr_o1;

  chacha_qr_host #(.QR_CYCLES(QR_CYC), .READ_LATENCY(RL0)) dut0 (
    .clk(clk), .rst(rst), .in_state(in_state0), .in_qr(in_qr0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_state(out_state0), .out_valid(out_valid0),
    .out_ready(out_ready0), .busy(busy0), .bus_data_o(bus_data_o0),
    .bus_addr_o(bus_addr_o0), .bus_wr_o(bus_wr_o0), .bus_qr_o(bus_qr_o0),
    .bus_data_i(bus_data_i0));

  chacha_qr_host #(.QR_CYCLES(1), .READ_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .in_state(in_state1), .in_qr(in_qr1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_state(out_state1), .out_valid(out_valid1),
    .out_ready(out_ready1), .busy(busy1), .bus_data_o(bus_data_o1),
    .bus_addr_o(bus_addr_o1), .bus_wr_o(bus_wr_o1), .bus_qr_o(bus_qr_o1),
    .bus_data_i(bus_data_i1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ChaCha quarter round on packed {d,c,b,a}.
  function automatic logic [127:0] qr_fn(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    a = s[31:0]; b = s[63:32]; c = s[95:64]; d = s[127:96];
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  // QR core responders: byte register file, qr on rising strobe, registered readback.
  logic [127:0] core0 = '0, core1 = '0;
  logic qr_d0 = 1'b0, qr_d1 = 1'b0;
  logic [7:0] core_q0 = 8'd0, core_q1a = 8'd0, core_q1b = 8'd0;
  always @(posedge clk) begin
    if (bus_wr_o0) core0[{bus_addr_o0, 3'b000} +: 8] <= bus_data_o0;
    if (bus_qr_o0 && !qr_d0) core0 <= qr_fn(core0);
    qr_d0   <= bus_qr_o0;
    core_q0 <= core0[{bus_addr_o0, 3'b000} +: 8];
    if (bus_wr_o1) core1[{bus_addr_o1, 3'b000} +: 8] <= bus_data_o1;
    if (bus_qr_o1 && !qr_d1) core1 <= qr_fn(core1);
    qr_d1    <= bus_qr_o1;
    core_q1a <= core1[{bus_addr_o1, 3'b000} +: 8];
    core_q1b <= core_q1a;
  end
  assign bus_data_i0 = core_q0;
  assign bus_data_i1 = core_q1b;

  // Transaction model of dut0: active flag, edges since acceptance, latched request.
  bit m_started = 1'b0;
  bit m_act = 1'b0;
  int m_n = 0;
  logic [127:0] m_in = '0, m_hold = '0;
  logic m_qr = 1'b0;

  function automatic int done_at(input logic q);
    return 32 + (q ? QR_CYC : 0) + RL0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_started <= 1'b1; m_act <= 1'b0; m_n <= 0; m_hold <= '0;
    end else if (!m_act) begin
      if (in_valid0) begin
        m_act <= 1'b1; m_n <= 0; m_in <= in_state0; m_qr <= in_qr0;
      end
    end else if (m_n >= done_at(m_qr)) begin
      if (out_ready0) m_act <= 1'b0;
    end else begin
      m_n <= m_n + 1;
      if (m_n + 1 == done_at(m_qr)) m_hold <= m_qr ? qr_fn(m_in) : m_in;
    end
  end

  // Per-cycle compare of dut0 against the model.
  always @(negedge clk) begin
    if (m_started) begin
      if (!m_act) begin
        chk("ctl_idle", {busy0, in_ready0, out_valid0}, {1'b0, !rst, 1'b0});
        chk("bus_idle", {bus_wr_o0, bus_qr_o0, bus_addr_o0, bus_data_o0}, 128'd0);
        chk("out_idle", out_state0, m_hold);
      end else begin
        int q, dn;
        logic [13:0] e_bus;
        q  = m_qr ? QR_CYC : 0;
        dn = done_at(m_qr);
        if (m_n < 16)           e_bus = {1'b1, 1'b0, 4'(m_n), m_in[m_n*8 +: 8]};
        else if (m_n < 16 + q)  e_bus = {1'b0, 1'b1, 4'd0, 8'd0};
        else if (m_n < 32 + q)  e_bus = {1'b0, 1'b0, 4'(m_n - 16 - q), 8'd0};
        else if (m_n < dn)      e_bus = {1'b0, 1'b0, 4'd15, 8'd0};
        else                    e_bus = 14'd0;
        chk("bus", {bus_wr_o0, bus_qr_o0, bus_addr_o0, bus_data_o0}, e_bus);
        chk("ctl_busy", {busy0, in_ready0, out_valid0}, {1'b1, 1'b0, m_n >= dn});
        if (m_n < 16 + q || m_n >= dn) chk("out_state", out_state0, m_hold);
      end
    end
  end

  // Strobe activity counters for the bus-trace test.
  int wr_cnt = 0, qr_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (bus_wr_o0) wr_cnt <= wr_cnt + 1;
    if (bus_qr_o0) qr_cnt <= qr_cnt + 1;
    if (bus_wr_o0 && bus_qr_o0) both_cnt <= both_cnt + 1;
  end

  // One dut0 transaction; in_valid stays high until the result handshake so
  // requests while busy (and on the handshake edge) must be ignored.
  task automatic run(input logic [127:0] s, input logic q, input int hold,
                     output int lat, output logic [127:0] res);
    bit acc;
    @(posedge clk); #2;
    in_state0 = s; in_qr0 = q; in_valid0 = 1'b1; acc = 1'b0;
    for (int g = 0; g < 50 && !acc; g++) begin
      acc = in_ready0;
      @(posedge clk); #2;
    end
    chk("accept", {127'd0, acc}, 128'd1);
    in_state0 = ~s; in_qr0 = ~q; out_ready0 = (hold == 0);
    lat = 0;
    while (!out_valid0 && lat < 200) begin
      @(posedge clk); #2; lat++;
    end
    chk("out_valid_seen", {127'd0, out_valid0}, 128'd1);
    res = out_state0;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #2; out_ready0 = 1'b1;
    end
    @(posedge clk); #2;
    out_ready0 = 1'b0; in_valid0 = 1'b0;
  endtask

  initial begin
    int lat, w0, q0, b0;
    logic [127:0] res;
    bit acc;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready0}, 128'd1);
    chk("rst_out_state", out_state0, 128'd0);
    chk("qr_model_pin", qr_fn(LB), QRES);

    // Loopback.
    run(LB, 1'b0, 0, lat, res);
    chk("lb_latency", lat, 128'd33);
    chk("lb_result", res, LB);

    // Quarter round.
    run(LB, 1'b1, 0, lat, res);
    chk("qr_latency", lat, 128'd34);
    chk("qr_result", res, QRES);

    // Bus trace.
    w0 = wr_cnt; q0 = qr_cnt; b0 = both_cnt;
    run(TRACE, 1'b1, 0, lat, res);
    chk("trace_wr_cycles", wr_cnt - w0, 128'd16);
    chk("trace_qr_cycles", qr_cnt - q0, QR_CYC);
    chk("trace_wr_with_qr", both_cnt - b0, 128'd0);
    chk("trace_result", res, qr_fn(TRACE));

    // Backpressure: out_ready low for 5 cycles after out_valid.
    run(128'hdeadbeef_cafef00d_0badc0de_12345678, 1'b0, 5, lat, res);
    chk("bp_result", res, 128'hdeadbeef_cafef00d_0badc0de_12345678);

    // Reset mid-WRITE while addr 7 is on the bus.
    @(posedge clk); #2;
    in_state0 = 128'h55555555_66666666_77777777_88888888; in_qr0 = 1'b0; in_valid0 = 1'b1;
    acc = 1'b0;
    for (int g = 0; g < 50 && !acc; g++) begin
      acc = in_ready0;
      @(posedge clk); #2;
    end
    in_valid0 = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("mid_write_addr", bus_addr_o0, 128'd7);
    #1 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {in_ready0, busy0}, 128'd2);
    chk("rst_mid_bus", {bus_wr_o0, bus_qr_o0, bus_addr_o0, bus_data_o0}, 128'd0);
    chk("rst_mid_out", {out_valid0, out_state0}, 129'd0);
    run(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1'b1, 0, lat, res);
    chk("after_rst_result", res, qr_fn(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0));

    // READ_LATENCY=2 loopback on dut1.
    @(posedge clk); #2;
    in_state1 = LB; in_qr1 = 1'b0; in_valid1 = 1'b1; acc = 1'b0;
    for (int g = 0; g < 50 && !acc; g++) begin
      acc = in_ready1;
      @(posedge clk); #2;
    end
    in_valid1 = 1'b0; in_state1 = '0;
    lat = 0;
    while (!out_valid1 && lat < 200) begin
      @(posedge clk); #2; lat++;
    end
    chk("rl2_latency", lat, 128'd34);
    chk("rl2_result", out_state1, LB);
    out_ready1 = 1'b1;
    @(posedge clk); #2 out_ready1 = 1'b0;
    @(negedge clk);
    chk("rl2_idle", {busy1, in_ready1, out_valid1}, 128'd2);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
